// File: rtl/cnn_ctrl_pkg.sv
// Shared definitions for the convolution controller write side.
package cnn_ctrl_pkg;

  // Response codes returned to the main controller on stall[1:0].
  localparam logic [1:0] STALL_PENDING = 2'b00;
  localparam logic [1:0] STALL_DONE    = 2'b10;
  localparam logic [1:0] STALL_FATAL   = 2'b11;

  // Write-control FSM states; every 2-bit code is a legal state.
  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StWrite = 2'b01,
    StAck   = 2'b10,
    StFail  = 2'b11
  } wr_state_e;

  // Stall code is a pure decode of the registered state.
  function automatic logic [1:0] stall_code(wr_state_e st);
    unique case (st)
      StAck:   return STALL_DONE;
      StFail:  return STALL_FATAL;
      default: return STALL_PENDING;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; push and pop may coincide at any level, including full.
module sync_fifo #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count
);

  localparam logic [ADDR_WIDTH:0] FullCnt = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] last_q, last_d;
  logic                  pop_acc, push_acc;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FullCnt);
  assign count    = count_q;
  // Head when non-empty, otherwise the most recently popped word.
  assign pop_data = empty ? last_q : mem_q[rd_ptr_q];

  // Next-state: accept pop/push, advance pointers, track fill count.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    pop_acc  = pop && !empty;
    push_acc = push && (!full || pop_acc);
    if (pop_acc) begin
      last_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_acc) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (push_acc && !pop_acc) begin
      count_d = count_q + 1'b1;
    end else if (pop_acc && !push_acc) begin
      count_d = count_q - 1'b1;
    end
  end

  // State registers; storage is cleared so out_data reads zero after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

endmodule

// File: rtl/result_write_ctrl.sv
// Accepts one result word per controller request, queues it and drains it to the consumer.
module result_write_ctrl
  import cnn_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_req,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [1:0]            stall,
  output logic                  fail,
  output logic                  proto_err,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   fill_level
);

  localparam int unsigned         WaitW       = $clog2(TIMEOUT);
  localparam logic [WaitW-1:0]    TimeoutLast = WaitW'(TIMEOUT - 1);

  wr_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [WaitW-1:0]      wait_cnt_q, wait_cnt_d;
  logic                  proto_err_q, proto_err_d;
  logic                  fifo_full, fifo_empty, can_push, push;

  sync_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(hold_q),
    .pop      (out_ready),
    .pop_data (out_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fill_level)
  );

  assign out_valid = !fifo_empty;
  // A full FIFO still takes the word if the head leaves on the same edge.
  assign can_push  = !fifo_full || (out_valid && out_ready);
  assign stall     = stall_code(state_q);
  assign fail      = (state_q == StFail);
  assign proto_err = proto_err_q;

  // FSM next-state, hold register capture, blocked-wait counting and protocol flag.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    wait_cnt_d  = wait_cnt_q;
    proto_err_d = proto_err_q | (wr_req && (state_q != StIdle));
    push        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (wr_req) begin
          hold_d     = wr_data;
          wait_cnt_d = '0;
          state_d    = StWrite;
        end
      end
      StWrite: begin
        if (can_push) begin
          push    = 1'b1;
          state_d = StAck;
        end else if (wait_cnt_q == TimeoutLast) begin
          state_d = StFail;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      StAck:   state_d = StIdle;
      StFail:  state_d = StFail;
      default: state_d = StIdle;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      wait_cnt_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      wait_cnt_q  <= wait_cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_result_write_ctrl.sv
// Directed and randomized checks of result_write_ctrl against a queue-based reference model.
module tb_result_write_ctrl;

  localparam int DW = 16;
  localparam int DEPTH = 4;
  localparam int AW = 2;
  localparam int TIMEOUT = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_req = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          out_ready = 1'b0;
  logic [1:0]    stall;
  logic          fail, proto_err, out_valid;
  logic [DW-1:0] out_data;
  logic [AW:0]   fill_level;

  result_write_ctrl #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_req    (wr_req),
    .wr_data   (wr_data),
    .stall     (stall),
    .fail      (fail),
    .proto_err (proto_err),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fill_level(fill_level)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: pending word, ack cycle, fatal flag, queue of stored words.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_hold, m_last;
  bit            m_pend, m_ack, m_fail, m_proto;
  int            m_wait;
  logic [DW-1:0] got[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    m_hold = '0; m_last = '0;
    m_pend = 0; m_ack = 0; m_fail = 0; m_proto = 0; m_wait = 0;
  endtask

  task automatic model_edge(input bit req, input logic [DW-1:0] d, input bit rdy);
    bit pop;
    bit do_push;
    pop = rdy && (mq.size() > 0);
    do_push = 0;
    if (req && (m_pend || m_ack || m_fail)) m_proto = 1;
    if (m_fail) begin
    end else if (m_ack) begin
      m_ack = 0;
    end else if (m_pend) begin
      if (mq.size() < DEPTH || pop) begin
        do_push = 1; m_pend = 0; m_ack = 1;
      end else if (m_wait == TIMEOUT - 1) begin
        m_pend = 0; m_fail = 1;
      end else begin
        m_wait++;
      end
    end else if (req) begin
      m_pend = 1; m_hold = d; m_wait = 0;
    end
    if (pop) m_last = mq.pop_front();
    if (do_push) mq.push_back(m_hold);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".stall"}, 32'(stall), m_fail ? 32'd3 : (m_ack ? 32'd2 : 32'd0));
    chk({tag, ".fail"}, 32'(fail), 32'(m_fail));
    chk({tag, ".proto_err"}, 32'(proto_err), 32'(m_proto));
    chk({tag, ".fill_level"}, 32'(fill_level), mq.size());
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() > 0));
    chk({tag, ".out_data"}, 32'(out_data), 32'(mq.size() > 0 ? mq[0] : m_last));
  endtask

  // One clock edge: record handshakes, advance DUT and model, compare everything.
  task automatic cyc(input string tag);
    bit r, rd;
    logic [DW-1:0] d;
    r = wr_req; d = wr_data; rd = out_ready;
    if (out_valid && out_ready) got.push_back(out_data);
    @(posedge clk);
    #1;
    model_edge(r, d, rd);
    check_all(tag);
  endtask

  task automatic request(input logic [DW-1:0] d, input string tag);
    wr_req = 1; wr_data = d;
    cyc(tag);
    wr_req = 0;
    cyc(tag);
    cyc(tag);
  endtask

  task automatic do_reset();
    wr_req = 0;
    reset = 1;
    #2;
    model_reset();
    check_all("reset_async");
    @(posedge clk);
    #1;
    reset = 0;
    check_all("reset_release");
  endtask

  initial begin
    logic [DW-1:0] sent[$];
    int fail_at;

    // Reset state
    model_reset();
    #1;
    check_all("reset");
    do_reset();

    // Single write into empty FIFO: stall 00,10,00
    wr_req = 1; wr_data = 16'h00A5;
    cyc("single.e0");
    chk("single.stall0", 32'(stall), 32'd0);
    wr_req = 0;
    cyc("single.e1");
    chk("single.stall1", 32'(stall), 32'd2);
    cyc("single.e2");
    chk("single.stall2", 32'(stall), 32'd0);
    chk("single.data", 32'(out_data), 32'h00A5);
    chk("single.fill", 32'(fill_level), 32'd1);

    // Second pulse while in WRITE: protocol error, only first word queued
    wr_req = 1; wr_data = 16'h0BB1;
    cyc("proto.e0");
    wr_data = 16'h0BB2;
    cyc("proto.e1");
    wr_req = 0;
    cyc("proto.e2");
    chk("proto.flag", 32'(proto_err), 32'd1);
    chk("proto.fill", 32'(fill_level), 32'd2);
    out_ready = 1;
    cyc("proto.drain0");
    chk("proto.second_word", 32'(out_data), 32'h0BB1);
    cyc("proto.drain1");
    chk("proto.empty", 32'(out_valid), 32'd0);
    chk("proto.hold_last", 32'(out_data), 32'h0BB1);
    do_reset();

    // Fill to DEPTH, block the 5th, then pop and push on the same edge
    out_ready = 0;
    request(16'h0011, "full.w1");
    request(16'h0022, "full.w2");
    request(16'h0033, "full.w3");
    request(16'h0044, "full.w4");
    chk("full.fill4", 32'(fill_level), 32'd4);
    wr_req = 1; wr_data = 16'h0055;
    cyc("full.req5");
    wr_req = 0;
    repeat (10) cyc("full.blocked");
    chk("full.stall_pending", 32'(stall), 32'd0);
    out_ready = 1;
    cyc("full.pop_push");
    chk("full.ack", 32'(stall), 32'd2);
    chk("full.fill_kept", 32'(fill_level), 32'd4);
    chk("full.head22", 32'(out_data), 32'h0022);
    repeat (6) cyc("full.drain");
    chk("full.drained", 32'(fill_level), 32'd0);

    // Back-to-back every 3 cycles with consumer always ready
    got.delete();
    for (int i = 0; i < 20; i++) begin
      logic [DW-1:0] w;
      w = DW'($urandom);
      sent.push_back(w);
      request(w, "b2b");
      chk("b2b.fill_le1", 32'(fill_level <= 1), 32'd1);
    end
    repeat (2) cyc("b2b.tail");
    chk("b2b.count", got.size(), 20);
    for (int i = 0; i < 20 && i < got.size(); i++) chk("b2b.order", 32'(got[i]), 32'(sent[i]));

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      out_ready = ($urandom_range(0, 1) == 1);
      if (!m_pend && !m_ack && !m_fail && ($urandom_range(0, 9) < 4)) begin
        wr_req = 1; wr_data = DW'($urandom);
      end else begin
        wr_req = 0;
      end
      cyc("rand");
    end
    wr_req = 0;

    // Timeout on a full FIFO -> fatal stall
    do_reset();
    out_ready = 0;
    for (int i = 0; i < DEPTH; i++) request(DW'(16'h0100 + i), "tmo.fill");
    wr_req = 1; wr_data = 16'h0DEAD;
    cyc("tmo.req");
    wr_req = 0;
    fail_at = -1;
    for (int k = 1; k <= TIMEOUT + 4; k++) begin
      cyc("tmo.wait");
      if (fail === 1'b1 && fail_at < 0) fail_at = k;
    end
    chk("tmo.fail_cycle", 32'(fail_at), 32'(TIMEOUT));
    chk("tmo.stall", 32'(stall), 32'd3);
    wr_req = 1; wr_data = 16'h0777;
    cyc("tmo.req_in_fail");
    wr_req = 0;
    cyc("tmo.after");
    chk("tmo.proto", 32'(proto_err), 32'd1);
    chk("tmo.fill_same", 32'(fill_level), 32'd4);
    out_ready = 1;
    repeat (5) cyc("tmo.drain");
    chk("tmo.still_fail", 32'(fail), 32'd1);
    chk("tmo.drained", 32'(fill_level), 32'd0);

    // Reset asserted while blocked in WRITE with a full FIFO
    do_reset();
    out_ready = 0;
    for (int i = 0; i < DEPTH; i++) request(DW'(16'h0200 + i), "rst.fill");
    wr_req = 1; wr_data = 16'h0BAD;
    cyc("rst.req");
    wr_req = 0;
    cyc("rst.blocked");
    reset = 1;
    #1;
    model_reset();
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.fill", 32'(fill_level), 32'd0);
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.data", 32'(out_data), 32'd0);
    chk("rst.fail", 32'(fail), 32'd0);
    chk("rst.proto", 32'(proto_err), 32'd0);
    @(posedge clk);
    #1;
    reset = 0;
    out_ready = 0;
    request(16'h1234, "rst.next");
    chk("rst.next_data", 32'(out_data), 32'h1234);
    chk("rst.next_fill", 32'(fill_level), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
